uart_tx_sched: RTL and testbench

//  Round-robin scheduler sharing one byte-level UART transmitter between NREQ requesters.

---
 rtl/uart_tx_sched.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one byte-level UART transmitter between NREQ requesters.
// A granted requester owns the engine for a whole packet; an idle gap separates packets.
module uart_tx_sched #(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 10416,
    parameter int HOLD_MAX   = 65535
) (
    input  logic              CLK100MHZ,
    input  logic              rst_ni,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [NREQ*8-1:0] req_data_i,
    input  logic [NREQ-1:0]   req_last_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic              tx_start_o,
    output logic [7:0]        tx_data_o,
    input  logic              tx_busy_i,
    input  logic              tx_done_i,
    output logic [NREQ-1:0]   grant_o,
    output logic              active_o
);

    localparam int IW = $clog2(NREQ);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int HW = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_GAP} state_t;

    state_t          state_reg, state_next;
    logic [NREQ-1:0] grant_reg, grant_next;
    logic [IW-1:0]   own_reg, own_next;
    logic [IW-1:0]   ptr_reg, ptr_next;
    logic            last_reg, last_next;
    logic            start_reg, start_next;
    logic [7:0]      data_reg, data_next;
    logic [GW-1:0]   gap_cnt_reg, gap_cnt_next;
    logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;

    logic [7:0]      req_byte [NREQ];
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic            own_valid;
    logic            accept;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_byte[gi] = req_data_i[8*gi +: 8];
        end
    endgenerate

    assign own_valid = req_valid_i[own_reg];
    assign accept    = (state_reg == S_SEND) && own_valid && !tx_busy_i;

    // First valid requester after the previous owner, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!pick_found && req_valid_i[(int'(ptr_reg) + i) % NREQ]) begin
                pick_found = 1'b1;
                pick_idx   = IW'((int'(ptr_reg) + i) % NREQ);
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= S_IDLE;
            grant_reg    <= '0;
            own_reg      <= '0;
            ptr_reg      <= IW'(NREQ - 1);
            last_reg     <= 1'b0;
            start_reg    <= 1'b0;
            data_reg     <= 8'h00;
            gap_cnt_reg  <= '0;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            own_reg      <= own_next;
            ptr_reg      <= ptr_next;
            last_reg     <= last_next;
            start_reg    <= start_next;
            data_reg     <= data_next;
            gap_cnt_reg  <= gap_cnt_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        own_next      = own_reg;
        ptr_next      = ptr_reg;
        last_next     = last_reg;
        start_next    = 1'b0;
        data_next     = data_reg;
        gap_cnt_next  = gap_cnt_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (pick_found) begin
                    state_next    = S_SEND;
                    own_next      = pick_idx;
                    grant_next    = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    hold_cnt_next = '0;
                end
            end
            S_SEND: begin
                if (accept) begin
                    start_next    = 1'b1;
                    data_next     = req_byte[own_reg];
                    last_next     = req_last_i[own_reg];
                    hold_cnt_next = '0;
                    state_next    = S_WAIT;
                end else if (!own_valid) begin
                    // Owner went quiet mid-packet: revoke without a gap.
                    if (hold_cnt_reg == HW'(HOLD_MAX - 1)) begin
                        ptr_next   = own_reg;
                        grant_next = '0;
                        state_next = S_IDLE;
                    end else begin
                        hold_cnt_next = hold_cnt_reg + 1'b1;
                    end
                end else begin
                    hold_cnt_next = '0;
                end
            end
            S_WAIT: begin
                if (tx_done_i) begin
                    if (last_reg) begin
                        ptr_next     = own_reg;
                        grant_next   = '0;
                        gap_cnt_next = '0;
                        state_next   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    end else begin
                        hold_cnt_next = '0;
                        state_next    = S_SEND;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_reg == GW'(GAP_CYCLES - 1)) begin
                    state_next = S_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = ((state_reg == S_SEND) && !tx_busy_i) ? grant_reg : '0;
        active_o    = (state_reg != S_IDLE);
    end

    assign grant_o    = grant_reg;
    assign tx_start_o = start_reg;
    assign tx_data_o  = data_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: single/multi-byte packets, round robin,
// busy stall, hold-timeout revoke and asynchronous reset during a frame.
module tb_uart_tx_sched;

    localparam int NREQ = 4;
    localparam int GAP  = 8;
    localparam int HOLD = 16;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*8-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy = 1'b0;
    logic              tx_done = 1'b0;
    logic [NREQ-1:0]   grant;
    logic              active;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_sched #(.NREQ(NREQ), .GAP_CYCLES(GAP), .HOLD_MAX(HOLD)) dut (
        .CLK100MHZ   (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .tx_start_o  (tx_start),
        .tx_data_o   (tx_data),
        .tx_busy_i   (tx_busy),
        .tx_done_i   (tx_done),
        .grant_o     (grant),
        .active_o    (active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
        req_valid[k]     = v;
        req_data[8*k +: 8] = d;
        req_last[k]      = l;
    endtask

    // Engine model: busy for n clocks after the start, then a one-cycle done.
    task automatic do_tx(input int n);
        tx_busy = 1'b1;
        repeat (n) tick();
        tx_busy = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (active && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) tick();
        n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL reset_start got=%b exp=0", tx_start); end
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got=%h exp=00", tx_data); end
        n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL reset_active got=%b exp=0", active); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        rst_ni = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_single_byte();
        int cyc;
        set_req(0, 1'b1, 8'hA5, 1'b1);
        tick();
        n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL single_grant got=%b exp=0001", grant); end
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        tick();
        set_req(0, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin n_bad++; $display("FAIL single_start got=%b/%h exp=1/a5", tx_start, tx_data); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL single_ready_wait got=%b exp=0000", req_ready); end
        tick();
        n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL single_start_pulse got=%b exp=0", tx_start); end
        do_tx(100);
        n_cmp++; if (grant !== 4'b0000 || active !== 1'b1) begin n_bad++; $display("FAIL single_gap_entry got=%b/%b exp=0000/1", grant, active); end
        wait_idle(cyc);
        n_cmp++; if (cyc != GAP) begin n_bad++; $display("FAIL single_gap_len got=%0d exp=%0d", cyc, GAP); end
        $display("test_single_byte done, gap=%0d", cyc);
    endtask

    task automatic test_multi_byte();
        int cyc;
        set_req(1, 1'b1, 8'h11, 1'b0);
        set_req(2, 1'b1, 8'h44, 1'b1);
        tick();
        n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL multi_grant got=%b exp=0010", grant); end
        tick();
        n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'h11) begin n_bad++; $display("FAIL multi_b0 got=%b/%h exp=1/11", tx_start, tx_data); end
        set_req(1, 1'b1, 8'h22, 1'b0);
        do_tx(5);
        n_cmp++; if (grant !== 4'b0010 || req_ready !== 4'b0010) begin n_bad++; $display("FAIL multi_keep got=%b/%b exp=0010/0010", grant, req_ready); end
        tick();
        n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'h22) begin n_bad++; $display("FAIL multi_b1 got=%b/%h exp=1/22", tx_start, tx_data); end
        set_req(1, 1'b1, 8'h33, 1'b1);
        do_tx(5);
        tick();
        n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'h33) begin n_bad++; $display("FAIL multi_b2 got=%b/%h exp=1/33", tx_start, tx_data); end
        set_req(1, 1'b0, 8'h00, 1'b0);
        do_tx(5);
        repeat (GAP) tick();
        n_cmp++; if (grant !== 4'b0000 || active !== 1'b0) begin n_bad++; $display("FAIL multi_gap got=%b/%b exp=0000/0", grant, active); end
        tick();
        n_cmp++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL multi_next_grant got=%b exp=0100", grant); end
        tick();
        n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'h44) begin n_bad++; $display("FAIL multi_req2 got=%b/%h exp=1/44", tx_start, tx_data); end
        set_req(2, 1'b0, 8'h00, 1'b0);
        do_tx(3);
        wait_idle(cyc);
        $display("test_multi_byte done");
    endtask

    task automatic test_round_robin();
        int order [5] = '{3, 0, 1, 2, 3};
        logic [NREQ-1:0] exp_g;
        logic [7:0] exp_d;
        for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 8'hC0 + 8'(k), 1'b1);
        for (int p = 0; p < 5; p++) begin
            exp_g = 4'b0001 << order[p];
            exp_d = 8'hC0 + 8'(order[p]);
            tick();
            n_cmp++; if (grant !== exp_g || tx_start !== 1'b0) begin n_bad++; $display("FAIL rr_grant%0d got=%b/%b exp=%b/0", p, grant, tx_start, exp_g); end
            tick();
            n_cmp++; if (tx_start !== 1'b1 || tx_data !== exp_d) begin n_bad++; $display("FAIL rr_start%0d got=%b/%h exp=1/%h", p, tx_start, tx_data, exp_d); end
            $display("rr packet %0d grant=%b data=%h", p, grant, tx_data);
            do_tx(3);
            repeat (GAP) tick();
        end
        req_valid = '0;
        $display("test_round_robin done");
    endtask

    task automatic test_busy_stall();
        int cyc;
        tx_busy = 1'b1;
        set_req(0, 1'b1, 8'h5A, 1'b1);
        tick();
        n_cmp++; if (grant !== 4'b0001 || req_ready !== 4'b0000) begin n_bad++; $display("FAIL busy_grant got=%b/%b exp=0001/0000", grant, req_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (tx_start !== 1'b0 || req_ready !== 4'b0000) begin n_bad++; $display("FAIL busy_hold%0d got=%b/%b exp=0/0000", i, tx_start, req_ready); end
        end
        tx_busy = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL busy_release got=%b exp=0001", req_ready); end
        tick();
        n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'h5A) begin n_bad++; $display("FAIL busy_start got=%b/%h exp=1/5a", tx_start, tx_data); end
        set_req(0, 1'b0, 8'h00, 1'b0);
        do_tx(2);
        wait_idle(cyc);
        $display("test_busy_stall done");
    endtask

    task automatic test_revoke();
        int cyc;
        set_req(1, 1'b1, 8'h77, 1'b0);
        set_req(3, 1'b1, 8'h99, 1'b1);
        tick();
        n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL revoke_grant got=%b exp=0010", grant); end
        tick();
        n_cmp++; if (tx_data !== 8'h77) begin n_bad++; $display("FAIL revoke_b0 got=%h exp=77", tx_data); end
        set_req(1, 1'b0, 8'h00, 1'b0);
        do_tx(2);
        repeat (HOLD - 1) tick();
        n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL revoke_early got=%b exp=0010", grant); end
        tick();
        n_cmp++; if (grant !== 4'b0000 || active !== 1'b0) begin n_bad++; $display("FAIL revoke_drop got=%b/%b exp=0000/0", grant, active); end
        tick();
        n_cmp++; if (grant !== 4'b1000) begin n_bad++; $display("FAIL revoke_nogap got=%b exp=1000", grant); end
        tick();
        n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'h99) begin n_bad++; $display("FAIL revoke_next got=%b/%h exp=1/99", tx_start, tx_data); end
        set_req(3, 1'b0, 8'h00, 1'b0);
        do_tx(2);
        wait_idle(cyc);
        $display("test_revoke done");
    endtask

    task automatic test_async_reset();
        set_req(2, 1'b1, 8'hE7, 1'b1);
        tick();
        n_cmp++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL arst_grant got=%b exp=0100", grant); end
        tick();
        set_req(2, 1'b0, 8'h00, 1'b0);
        tx_busy = 1'b1;
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (grant !== 4'b0000 || tx_start !== 1'b0 || tx_data !== 8'h00 || active !== 1'b0) begin
            n_bad++; $display("FAIL arst_async got=%b/%b/%h/%b exp=0000/0/00/0", grant, tx_start, tx_data, active);
        end
        tick();
        rst_ni = 1'b1;
        tx_busy = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_cmp++; if (active !== 1'b0 || grant !== 4'b0000 || tx_start !== 1'b0) begin n_bad++; $display("FAIL arst_done_ignored got=%b/%b/%b exp=0/0000/0", active, grant, tx_start); end
        tick();
        n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL arst_idle got=%b exp=0", active); end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_multi_byte();
        test_round_robin();
        test_busy_stall();
        test_revoke();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
